// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode, select, state and control-bundle definitions for the ALU op sequencer.
package alu_pkg;

    localparam int unsigned OP_ADD  = 32'd0;
    localparam int unsigned OP_SUB  = 32'd1;
    localparam int unsigned OP_AND  = 32'd2;
    localparam int unsigned OP_OR   = 32'd3;
    localparam int unsigned OP_XOR  = 32'd4;
    localparam int unsigned OP_NOT  = 32'd5;
    localparam int unsigned OP_SHL  = 32'd6;
    localparam int unsigned OP_SHR  = 32'd7;
    localparam int unsigned OP_MUL  = 32'd8;
    localparam int unsigned OP_MOVA = 32'd9;
    localparam int unsigned OP_MOVB = 32'd10;
    localparam int unsigned OP_LAST = 32'd10;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;
    localparam logic [1:0] SEL_NOT = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic       arith;
        logic       sub;
        logic       logic_op;
        logic [1:0] sel;
        logic       shift;
        logic       shr;
        logic       mul;
        logic       trans;
        logic       tsel;
    } alu_ctrl_t;

    localparam alu_ctrl_t CTRL_NONE = 10'b0;

    // Number of primary strobes active in a bundle; a legal bundle has at most one.
    function automatic logic [2:0] strobe_count(input alu_ctrl_t c);
        return 3'(c.arith) + 3'(c.logic_op) + 3'(c.shift) + 3'(c.mul) + 3'(c.trans);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: maps an opcode to a one-hot ALU control bundle.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    output alu_ctrl_t       ctrl,
    output logic            legal,
    output logic            is_mul
);

    // Decode table; anything past OP_LAST yields an empty bundle and legal=0.
    always_comb begin
        ctrl   = CTRL_NONE;
        legal  = 1'b1;
        is_mul = 1'b0;
        case (32'(op))
            OP_ADD:  ctrl.arith = 1'b1;
            OP_SUB:  begin ctrl.arith = 1'b1; ctrl.sub = 1'b1; end
            OP_AND:  begin ctrl.logic_op = 1'b1; ctrl.sel = SEL_AND; end
            OP_OR:   begin ctrl.logic_op = 1'b1; ctrl.sel = SEL_OR;  end
            OP_XOR:  begin ctrl.logic_op = 1'b1; ctrl.sel = SEL_XOR; end
            OP_NOT:  begin ctrl.logic_op = 1'b1; ctrl.sel = SEL_NOT; end
            OP_SHL:  ctrl.shift = 1'b1;
            OP_SHR:  begin ctrl.shift = 1'b1; ctrl.shr = 1'b1; end
            OP_MUL:  begin ctrl.mul = 1'b1; is_mul = 1'b1; end
            OP_MOVA: ctrl.trans = 1'b1;
            OP_MOVB: begin ctrl.trans = 1'b1; ctrl.tsel = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Handshaked ALU control sequencer: one opcode per transaction, registered strobes,
// multi-cycle MUL hold, illegal-op flagging and a completed-op counter.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int OP_W       = 4,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             flush,
    output logic             arith_op,
    output logic             sub,
    output logic             logic_op,
    output logic [1:0]       logic_sel,
    output logic             shift_op,
    output logic             shift_right,
    output logic             mul_op,
    output logic             trans_op,
    output logic             trans_sel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    logic [1:0]       state_q, state_d;
    alu_ctrl_t        ctrl_q, ctrl_d;
    logic [7:0]       mul_cnt_q, mul_cnt_d;
    logic             res_valid_q, res_valid_d;
    logic             res_err_q, res_err_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    alu_ctrl_t dec_ctrl_s;
    logic      dec_legal_s;
    logic      dec_is_mul_s;
    logic      accept_s;

    alu_op_decode #(.OP_W(OP_W)) u_decode (
        .op     (op),
        .ctrl   (dec_ctrl_s),
        .legal  (dec_legal_s),
        .is_mul (dec_is_mul_s)
    );

    assign op_ready = (state_q == ST_IDLE) && !flush;
    assign accept_s = op_valid && op_ready;

    // Next-state logic; strobes are computed one cycle ahead so they come straight off flops.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        mul_cnt_d   = mul_cnt_q;
        res_valid_d = res_valid_q;
        res_err_d   = res_err_q;
        done_cnt_d  = done_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!dec_legal_s) begin
                        state_d     = ST_DONE;
                        ctrl_d      = CTRL_NONE;
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                    end else if (dec_is_mul_s) begin
                        state_d   = ST_MUL;
                        ctrl_d    = dec_ctrl_s;
                        mul_cnt_d = 8'(MUL_CYCLES - 1);
                    end else begin
                        state_d = ST_EXEC;
                        ctrl_d  = dec_ctrl_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d     = ST_DONE;
                ctrl_d      = CTRL_NONE;
                res_valid_d = 1'b1;
                res_err_d   = 1'b0;
            end
            ST_MUL: begin
                if (mul_cnt_q == 8'd0) begin
                    state_d     = ST_DONE;
                    ctrl_d      = CTRL_NONE;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b0;
                end else begin
                    mul_cnt_d = mul_cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    done_cnt_d  = done_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                ctrl_d      = CTRL_NONE;
                res_valid_d = 1'b0;
                res_err_d   = 1'b0;
            end
        endcase
        // Flush overrides everything above, including a pending accept or handshake.
        if (flush) begin
            state_d     = ST_IDLE;
            ctrl_d      = CTRL_NONE;
            mul_cnt_d   = 8'd0;
            res_valid_d = 1'b0;
            res_err_d   = 1'b0;
            done_cnt_d  = done_cnt_q;
        end else begin
            mul_cnt_d = mul_cnt_d;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= CTRL_NONE;
            mul_cnt_q   <= 8'd0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            mul_cnt_q   <= mul_cnt_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign arith_op    = ctrl_q.arith;
    assign sub         = ctrl_q.sub;
    assign logic_op    = ctrl_q.logic_op;
    assign logic_sel   = ctrl_q.sel;
    assign shift_op    = ctrl_q.shift;
    assign shift_right = ctrl_q.shr;
    assign mul_op      = ctrl_q.mul;
    assign trans_op    = ctrl_q.trans;
    assign trans_sel   = ctrl_q.tsel;
    assign res_valid   = res_valid_q;
    assign res_err     = res_err_q;
    assign busy        = busy_q;
    assign done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer (MUL_CYCLES=4, CNT_W=4).
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] op = 4'd0;
    logic       flush = 1'b0;
    logic       arith_op, sub, logic_op, shift_op, shift_right, mul_op, trans_op, trans_sel;
    logic [1:0] logic_sel;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       res_err;
    logic       busy;
    logic [3:0] done_cnt;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_cnt = 4'd0;

    alu_op_sequencer #(.OP_W(4), .MUL_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .flush(flush), .arith_op(arith_op), .sub(sub), .logic_op(logic_op),
        .logic_sel(logic_sel), .shift_op(shift_op), .shift_right(shift_right),
        .mul_op(mul_op), .trans_op(trans_op), .trans_sel(trans_sel),
        .res_valid(res_valid), .res_ready(res_ready), .res_err(res_err),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    wire [9:0] ctrl_w = {arith_op, sub, logic_op, logic_sel, shift_op, shift_right,
                         mul_op, trans_op, trans_sel};

    // Hand-written strobe table: {arith,sub,logic,sel[1:0],shift,shr,mul,trans,tsel}.
    function automatic logic [9:0] exp_ctrl(input int code);
        case (code)
            0:       return 10'b1_0_0_00_0_0_0_0_0;
            1:       return 10'b1_1_0_00_0_0_0_0_0;
            2:       return 10'b0_0_1_00_0_0_0_0_0;
            3:       return 10'b0_0_1_01_0_0_0_0_0;
            4:       return 10'b0_0_1_10_0_0_0_0_0;
            5:       return 10'b0_0_1_11_0_0_0_0_0;
            6:       return 10'b0_0_0_00_1_0_0_0_0;
            7:       return 10'b0_0_0_00_1_1_0_0_0;
            8:       return 10'b0_0_0_00_0_0_1_0_0;
            9:       return 10'b0_0_0_00_0_0_0_1_0;
            10:      return 10'b0_0_0_00_0_0_0_1_1;
            default: return 10'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({ctrl_w, res_valid, res_err, busy, done_cnt} !== 17'b0) begin
            errors++; $display("FAIL reset_in_reset got %h want 0", {ctrl_w, res_valid, res_err, busy, done_cnt});
        end
        step(); rst_n = 1'b1; step();
        checks++;
        if (op_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release op_ready=%b busy=%b want 1 0", op_ready, busy);
        end
    endtask

    task automatic test_sub();
        op = 4'd1; op_valid = 1'b1;
        step(); op_valid = 1'b0;
        checks++;
        if (ctrl_w !== exp_ctrl(1) || res_valid !== 1'b0 || op_ready !== 1'b0) begin
            errors++; $display("FAIL sub_t1 ctrl=%b rv=%b rdy=%b want %b 0 0", ctrl_w, res_valid, op_ready, exp_ctrl(1));
        end
        step();
        checks++;
        if (ctrl_w !== 10'b0 || res_valid !== 1'b1 || res_err !== 1'b0) begin
            errors++; $display("FAIL sub_t2 ctrl=%b rv=%b err=%b want 0 1 0", ctrl_w, res_valid, res_err);
        end
        res_ready = 1'b1; step(); res_ready = 1'b0; exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (done_cnt !== exp_cnt || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL sub_hs cnt=%0d rv=%b busy=%b want %0d 0 0", done_cnt, res_valid, busy, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_mul();
        op = 4'd8; op_valid = 1'b1;
        step(); op_valid = 1'b0;
        step();
        checks++;
        if (mul_op !== 1'b1 || done_cnt !== exp_cnt) begin
            errors++; $display("FAIL rstmul_pre mul=%b cnt=%0d want 1 %0d", mul_op, done_cnt, exp_cnt);
        end
        rst_n = 1'b0; #1;
        exp_cnt = 4'd0;
        checks++;
        if ({ctrl_w, res_valid, res_err, busy, done_cnt} !== 17'b0) begin
            errors++; $display("FAIL rstmul_async got %h want 0", {ctrl_w, res_valid, res_err, busy, done_cnt});
        end
        step(); rst_n = 1'b1; step();
        checks++;
        if (op_ready !== 1'b1 || mul_op !== 1'b0) begin
            errors++; $display("FAIL rstmul_release rdy=%b mul=%b want 1 0", op_ready, mul_op);
        end
    endtask

    task automatic test_mul();
        op = 4'd8; op_valid = 1'b1;
        step(); op_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (ctrl_w !== exp_ctrl(8) || res_valid !== 1'b0) begin
                errors++; $display("FAIL mul_hold_%0d ctrl=%b rv=%b want %b 0", i, ctrl_w, res_valid, exp_ctrl(8));
            end
            step();
        end
        checks++;
        if (mul_op !== 1'b0 || res_valid !== 1'b1 || res_err !== 1'b0) begin
            errors++; $display("FAIL mul_done mul=%b rv=%b err=%b want 0 1 0", mul_op, res_valid, res_err);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (res_valid !== 1'b1 || op_ready !== 1'b0 || done_cnt !== exp_cnt) begin
                errors++; $display("FAIL mul_stall_%0d rv=%b rdy=%b cnt=%0d want 1 0 %0d", i, res_valid, op_ready, done_cnt, exp_cnt);
            end
        end
        res_ready = 1'b1; step(); res_ready = 1'b0; exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (done_cnt !== exp_cnt || res_valid !== 1'b0) begin
            errors++; $display("FAIL mul_hs cnt=%0d rv=%b want %0d 0", done_cnt, res_valid, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        op = 4'd13; op_valid = 1'b1;
        step(); op_valid = 1'b0;
        checks++;
        if (ctrl_w !== 10'b0 || res_valid !== 1'b1 || res_err !== 1'b1) begin
            errors++; $display("FAIL illegal_t1 ctrl=%b rv=%b err=%b want 0 1 1", ctrl_w, res_valid, res_err);
        end
        res_ready = 1'b1; step(); res_ready = 1'b0; exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (done_cnt !== exp_cnt || res_err !== 1'b0 || ctrl_w !== 10'b0) begin
            errors++; $display("FAIL illegal_hs cnt=%0d err=%b ctrl=%b want %0d 0 0", done_cnt, res_err, ctrl_w, exp_cnt);
        end
    endtask

    task automatic test_flush();
        op = 4'd8; op_valid = 1'b1;
        step(); op_valid = 1'b0;
        step();
        flush = 1'b1; step(); flush = 1'b0;
        checks++;
        if (mul_op !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL flush_mul mul=%b busy=%b rv=%b want 0 0 0", mul_op, busy, res_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (res_valid !== 1'b0 || done_cnt !== exp_cnt || mul_op !== 1'b0) begin
                errors++; $display("FAIL flush_after_%0d rv=%b cnt=%0d mul=%b want 0 %0d 0", i, res_valid, done_cnt, mul_op, exp_cnt);
            end
        end
        flush = 1'b1; op = 4'd0; op_valid = 1'b1; #1;
        checks++;
        if (op_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready got %b want 0", op_ready);
        end
        step(); flush = 1'b0; op_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || arith_op !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL flush_noaccept busy=%b arith=%b rv=%b want 0 0 0", busy, arith_op, res_valid);
        end
    endtask

    task automatic test_back_to_back();
        int code;
        bit seen;
        rst_n = 1'b0; #1; step(); rst_n = 1'b1; exp_cnt = 4'd0;
        res_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            code = k % 11;
            op = 4'(code); op_valid = 1'b1;
            step(); op_valid = 1'b0;
            checks++;
            if (ctrl_w !== exp_ctrl(code)) begin
                errors++; $display("FAIL sweep_ctrl op=%0d got %b want %b", code, ctrl_w, exp_ctrl(code));
            end
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                checks++;
                if (($countones({arith_op, logic_op, shift_op, mul_op, trans_op}) > 1) ||
                    (!arith_op && sub) || (!logic_op && logic_sel != 2'b00) ||
                    (!shift_op && shift_right) || (!trans_op && trans_sel)) begin
                    errors++; $display("FAIL sweep_onehot op=%0d ctrl=%b want one-hot", code, ctrl_w);
                end
                if (res_valid === 1'b1) seen = 1'b1;
                else step();
            end
            checks++;
            if (!seen) begin
                errors++; $display("FAIL sweep_timeout op=%0d rv=%b want 1", code, res_valid);
            end
            step(); exp_cnt = exp_cnt + 4'd1;
            checks++;
            if (done_cnt !== exp_cnt || busy !== 1'b0) begin
                errors++; $display("FAIL sweep_cnt k=%0d got %0d busy=%b want %0d 0", k, done_cnt, busy, exp_cnt);
            end
        end
        res_ready = 1'b0;
        checks++;
        if (done_cnt !== 4'd4) begin
            errors++; $display("FAIL sweep_final cnt=%0d want 4", done_cnt);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_sub();
        test_reset_mid_mul();
        test_mul();
        test_illegal();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
